// File: rtl/dmem_port_arbiter.sv
// DTCM port arbiter between the load unit and the store-buffer drain.
// Optional perf counters are built only with DMEM_ARB_PERF_EN defined.
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int SB_HIGH_WM   = 6,
    parameter int SB_LOW_WM    = 2,
    parameter int BURST_MAX    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req_valid,
    input  logic [31:0] ld_req_addr,
    output logic        ld_req_ready,
    input  logic        sb_req_valid,
    input  logic [31:0] sb_req_addr,
    input  logic [31:0] sb_req_data,
    input  logic [3:0]  sb_req_byte_sel,
    input  logic [3:0]  sb_count,
    output logic        sb_req_ready,
    input  logic        recovery_stall,
    input  logic        flush,
    output logic        dmem_en,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        ld_data_pending,
    output logic [31:0] perf_ld_block_cnt,
    output logic [31:0] perf_st_grant_cnt
);

    typedef enum logic [0:0] {
        LOAD_PRI    = 1'b0,
        STORE_BURST = 1'b1
    } state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_nxt;
    logic [BW-1:0]   burst_cnt;
    logic [BW-1:0]   burst_nxt;

    logic            active;
    logic            ld_gnt;
    logic            st_gnt;
    logic            sb_high;
    logic            sb_low;
    logic            starve_hit;
    logic            burst_done;

    // Grants are only possible out of reset and while the pipe is not frozen
    assign active  = rst & ~recovery_stall;

    // Occupancy thresholds use the count seen before this cycle's grant
    assign sb_high = int'(sb_count) >= SB_HIGH_WM;
    assign sb_low  = int'(sb_count) <= (SB_LOW_WM + 1);

    // Priority grant: loads first in LOAD_PRI, stores first in STORE_BURST
    always_comb begin
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        if (active) begin
            unique case (state)
                LOAD_PRI: begin
                    ld_gnt = ld_req_valid;
                    st_gnt = sb_req_valid & ~ld_req_valid;
                end
                STORE_BURST: begin
                    st_gnt = sb_req_valid;
                    ld_gnt = ld_req_valid & ~sb_req_valid;
                end
                default: begin
                    ld_gnt = 1'b0;
                    st_gnt = 1'b0;
                end
            endcase
        end
    end

    assign ld_req_ready = ld_gnt;
    assign sb_req_ready = st_gnt;

    // Starvation counter: counts stores losing to loads, saturates at limit
    always_comb begin
        starve_nxt = starve_cnt;
        if (st_gnt) begin
            starve_nxt = '0;
        end else if (state == LOAD_PRI && sb_req_valid
                     && int'(starve_cnt) < STARVE_LIMIT) begin
            starve_nxt = starve_cnt + SW'(1);
        end
    end

    // Burst counter: held at zero in LOAD_PRI so every burst starts clean
    always_comb begin
        burst_nxt = burst_cnt;
        if (state == LOAD_PRI) begin
            burst_nxt = '0;
        end else if (st_gnt && int'(burst_cnt) < BURST_MAX) begin
            burst_nxt = burst_cnt + BW'(1);
        end
    end

    assign starve_hit = int'(starve_nxt) >= STARVE_LIMIT;
    assign burst_done = int'(burst_nxt) >= BURST_MAX;

    // Next-state logic for the load/store priority FSM
    always_comb begin
        state_nxt = state;
        unique case (state)
            LOAD_PRI: begin
                if (sb_high || starve_hit) begin
                    state_nxt = STORE_BURST;
                end
            end
            STORE_BURST: begin
                if (!sb_req_valid) begin
                    state_nxt = LOAD_PRI;
                end else if (st_gnt && (burst_done || sb_low)) begin
                    state_nxt = LOAD_PRI;
                end
            end
            default: begin
                state_nxt = LOAD_PRI;
            end
        endcase
    end

    // State and arbitration counters; frozen while recovery_stall is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LOAD_PRI;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else if (!recovery_stall) begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    // Read response flag; flush wins over both a new grant and a stall hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_data_pending <= 1'b0;
        end else if (flush) begin
            ld_data_pending <= 1'b0;
        end else if (!recovery_stall) begin
            ld_data_pending <= ld_gnt;
        end
    end

    // DTCM port mux driven straight from the current grant
    always_comb begin
        dmem_en    = 1'b0;
        dmem_we    = 4'h0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        unique case (1'b1)
            ld_gnt: begin
                dmem_en   = 1'b1;
                dmem_addr = ld_req_addr;
            end
            st_gnt: begin
                dmem_en    = 1'b1;
                dmem_we    = sb_req_byte_sel;
                dmem_addr  = sb_req_addr;
                dmem_wdata = sb_req_data;
            end
            default: begin
                dmem_en = 1'b0;
            end
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] ld_block_q;
    logic [31:0] st_grant_q;

    // Free-running perf counters; no grants occur during a stall so they hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_block_q <= 32'h0;
            st_grant_q <= 32'h0;
        end else begin
            if (st_gnt && ld_req_valid) begin
                ld_block_q <= ld_block_q + 32'd1;
            end
            if (st_gnt) begin
                st_grant_q <= st_grant_q + 32'd1;
            end
        end
    end

    assign perf_ld_block_cnt = ld_block_q;
    assign perf_st_grant_cnt = st_grant_q;
`else
    assign perf_ld_block_cnt = 32'h0;
    assign perf_st_grant_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter.
// Each task drives one scenario and checks hand-computed values inline.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ld_req_valid = 1'b0;
    logic [31:0] ld_req_addr = 32'h0;
    logic        ld_req_ready;
    logic        sb_req_valid = 1'b0;
    logic [31:0] sb_req_addr = 32'h0;
    logic [31:0] sb_req_data = 32'h0;
    logic [3:0]  sb_req_byte_sel = 4'h0;
    logic [3:0]  sb_count = 4'h0;
    logic        sb_req_ready;
    logic        recovery_stall = 1'b0;
    logic        flush = 1'b0;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        ld_data_pending;
    logic [31:0] perf_ld_block_cnt;
    logic [31:0] perf_st_grant_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .ld_req_valid      (ld_req_valid),
        .ld_req_addr       (ld_req_addr),
        .ld_req_ready      (ld_req_ready),
        .sb_req_valid      (sb_req_valid),
        .sb_req_addr       (sb_req_addr),
        .sb_req_data       (sb_req_data),
        .sb_req_byte_sel   (sb_req_byte_sel),
        .sb_count          (sb_count),
        .sb_req_ready      (sb_req_ready),
        .recovery_stall    (recovery_stall),
        .flush             (flush),
        .dmem_en           (dmem_en),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .ld_data_pending   (ld_data_pending),
        .perf_ld_block_cnt (perf_ld_block_cnt),
        .perf_st_grant_cnt (perf_st_grant_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ld_req_valid    = 1'b0;
        sb_req_valid    = 1'b0;
        sb_count        = 4'h0;
        recovery_stall  = 1'b0;
        flush           = 1'b0;
        ld_req_addr     = 32'h0000_0100;
        sb_req_addr     = 32'h0000_0200;
        sb_req_data     = 32'hCAFE_0001;
        sb_req_byte_sel = 4'hA;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd6;
        step();
        settle();
        tests++;
        if (ld_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ld_ready got %b want 0", ld_req_ready);
        end
        tests++;
        if (sb_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_sb_ready got %b want 0", sb_req_ready);
        end
        tests++;
        if (dmem_en !== 1'b0 || dmem_we !== 4'h0) begin
            fails++;
            $display("FAIL reset_dmem en=%b we=%h want 0/0", dmem_en, dmem_we);
        end
        tests++;
        if (ld_data_pending !== 1'b0) begin
            fails++;
            $display("FAIL reset_pending got %b want 0", ld_data_pending);
        end
        tests++;
        if (perf_st_grant_cnt !== 32'h0 || perf_ld_block_cnt !== 32'h0) begin
            fails++;
            $display("FAIL reset_perf st=%0d blk=%0d want 0/0",
                     perf_st_grant_cnt, perf_ld_block_cnt);
        end
    endtask

    task automatic test_starve();
        logic       exp_ld;
        logic       exp_sb;
        logic       exp_pend;
        logic [31:0] exp_addr;
        logic [3:0] exp_we;
        do_reset();
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd3;
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_ld   = (c != 4);
            exp_sb   = (c == 4);
            exp_pend = (c >= 1 && c <= 4);
            exp_addr = (c == 4) ? 32'h0000_0200 : 32'h0000_0100;
            exp_we   = (c == 4) ? 4'hA : 4'h0;
            tests++;
            if (ld_req_ready !== exp_ld || sb_req_ready !== exp_sb) begin
                fails++;
                $display("FAIL starve_grant c%0d got ld=%b sb=%b want ld=%b sb=%b",
                         c, ld_req_ready, sb_req_ready, exp_ld, exp_sb);
            end
            tests++;
            if (dmem_addr !== exp_addr || dmem_we !== exp_we) begin
                fails++;
                $display("FAIL starve_dmem c%0d got addr=%h we=%h want %h/%h",
                         c, dmem_addr, dmem_we, exp_addr, exp_we);
            end
            tests++;
            if (ld_data_pending !== exp_pend) begin
                fails++;
                $display("FAIL starve_pending c%0d got %b want %b",
                         c, ld_data_pending, exp_pend);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_high_wm();
        logic exp_ld;
        logic exp_sb;
        do_reset();
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd6;
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_sb = (c >= 1 && c <= 4);
            exp_ld = !exp_sb;
            tests++;
            if (ld_req_ready !== exp_ld || sb_req_ready !== exp_sb
                || dmem_en !== 1'b1) begin
                fails++;
                $display("FAIL high_wm c%0d got ld=%b sb=%b en=%b want ld=%b sb=%b en=1",
                         c, ld_req_ready, sb_req_ready, dmem_en, exp_ld, exp_sb);
            end
            if (c == 2) begin
                tests++;
                if (dmem_wdata !== 32'hCAFE_0001) begin
                    fails++;
                    $display("FAIL high_wm_wdata got %h want cafe0001", dmem_wdata);
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_burst_exit();
        do_reset();
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd6;
        step();
        sb_req_valid = 1'b0;
        settle();
        tests++;
        if (ld_req_ready !== 1'b1 || sb_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL burst_empty got ld=%b sb=%b want ld=1 sb=0",
                     ld_req_ready, sb_req_ready);
        end
        step();
        sb_req_valid = 1'b1;
        sb_count = 4'd0;
        settle();
        tests++;
        if (ld_req_ready !== 1'b1 || sb_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL burst_exit got ld=%b sb=%b want ld=1 sb=0",
                     ld_req_ready, sb_req_ready);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        ld_req_valid = 1'b1;
        ld_req_addr = 32'h0000_0040;
        settle();
        tests++;
        if (ld_req_ready !== 1'b1 || dmem_addr !== 32'h0000_0040) begin
            fails++;
            $display("FAIL flush_ld0 got rdy=%b addr=%h want 1/00000040",
                     ld_req_ready, dmem_addr);
        end
        step();
        flush = 1'b1;
        settle();
        tests++;
        if (ld_data_pending !== 1'b1 || dmem_en !== 1'b1
            || ld_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_cycle got pend=%b en=%b rdy=%b want 1/1/1",
                     ld_data_pending, dmem_en, ld_req_ready);
        end
        step();
        ld_req_valid = 1'b0;
        sb_req_valid = 1'b1;
        settle();
        tests++;
        if (ld_data_pending !== 1'b0) begin
            fails++;
            $display("FAIL flush_pending got %b want 0", ld_data_pending);
        end
        tests++;
        if (sb_req_ready !== 1'b1 || dmem_we !== 4'hA) begin
            fails++;
            $display("FAIL flush_store got rdy=%b we=%h want 1/a",
                     sb_req_ready, dmem_we);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_stall();
        logic exp_sb;
        do_reset();
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd6;
        step();
        for (int c = 0; c < 2; c++) begin
            settle();
            tests++;
            if (sb_req_ready !== 1'b1) begin
                fails++;
                $display("FAIL stall_pre c%0d got sb=%b want 1", c, sb_req_ready);
            end
            step();
        end
        recovery_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            tests++;
            if (ld_req_ready !== 1'b0 || sb_req_ready !== 1'b0
                || dmem_en !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold c%0d got ld=%b sb=%b en=%b want 0/0/0",
                         c, ld_req_ready, sb_req_ready, dmem_en);
            end
            step();
        end
        recovery_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            exp_sb = (c < 2);
            tests++;
            if (sb_req_ready !== exp_sb || ld_req_ready !== !exp_sb) begin
                fails++;
                $display("FAIL stall_post c%0d got ld=%b sb=%b want sb=%b",
                         c, ld_req_ready, sb_req_ready, exp_sb);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_stall_pending();
        do_reset();
        ld_req_valid = 1'b1;
        step();
        recovery_stall = 1'b1;
        settle();
        tests++;
        if (ld_data_pending !== 1'b1 || ld_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_pend0 got pend=%b rdy=%b want 1/0",
                     ld_data_pending, ld_req_ready);
        end
        step();
        tests++;
        if (ld_data_pending !== 1'b1) begin
            fails++;
            $display("FAIL stall_pend_hold got %b want 1", ld_data_pending);
        end
        flush = 1'b1;
        step();
        tests++;
        if (ld_data_pending !== 1'b0) begin
            fails++;
            $display("FAIL stall_flush got %b want 0", ld_data_pending);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        ld_req_valid = 1'b1;
        sb_req_valid = 1'b1;
        sb_count = 4'd6;
        step();
        settle();
        tests++;
        if (sb_req_ready !== 1'b1 || ld_data_pending !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre got sb=%b pend=%b want 1/1",
                     sb_req_ready, ld_data_pending);
        end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if (ld_req_ready !== 1'b0 || sb_req_ready !== 1'b0
            || dmem_en !== 1'b0 || dmem_we !== 4'h0
            || ld_data_pending !== 1'b0) begin
            fails++;
            $display("FAIL arst_now got ld=%b sb=%b en=%b we=%h pend=%b want 0",
                     ld_req_ready, sb_req_ready, dmem_en, dmem_we, ld_data_pending);
        end
        repeat (2) step();
        rst = 1'b1;
        sb_count = 4'd3;
        settle();
        tests++;
        if (ld_req_ready !== 1'b1 || sb_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL arst_after got ld=%b sb=%b want 1/0",
                     ld_req_ready, sb_req_ready);
        end
        idle_inputs();
    endtask

    task automatic test_perf();
        logic [31:0] exp_st;
        logic [31:0] exp_blk;
`ifdef DMEM_ARB_PERF_EN
        exp_st  = 32'd10;
        exp_blk = 32'd3;
`else
        exp_st  = 32'd0;
        exp_blk = 32'd0;
`endif
        do_reset();
        sb_req_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            settle();
            tests++;
            if (sb_req_ready !== 1'b1) begin
                fails++;
                $display("FAIL perf_store c%0d got %b want 1", c, sb_req_ready);
            end
            step();
        end
        ld_req_valid = 1'b1;
        sb_count = 4'd3;
        for (int b = 0; b < 3; b++) begin
            repeat (4) step();
            settle();
            tests++;
            if (sb_req_ready !== 1'b1 || ld_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL perf_block b%0d got sb=%b ld=%b want 1/0",
                         b, sb_req_ready, ld_req_ready);
            end
            step();
        end
        idle_inputs();
        settle();
        tests++;
        if (perf_st_grant_cnt !== exp_st) begin
            fails++;
            $display("FAIL perf_st got %0d want %0d", perf_st_grant_cnt, exp_st);
        end
        tests++;
        if (perf_ld_block_cnt !== exp_blk) begin
            fails++;
            $display("FAIL perf_blk got %0d want %0d", perf_ld_block_cnt, exp_blk);
        end
    endtask

    initial begin
        test_reset();
        test_starve();
        test_high_wm();
        test_burst_exit();
        test_flush();
        test_stall();
        test_stall_pending();
        test_async_reset();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
